usb_tx_data_packetizer: RTL
===========================

Name: usb_tx_data_packetizer

Overview:
Transmit-side framer for USB DATA0/DATA1/DATA2/MDATA packets. It sits between the endpoint transmit buffer and the bit-level NRZI/bit-stuff encoder. It emits the PID byte, then the payload bytes, then the 16-bit data CRC, all as a byte stream. The CRC16 is computed internally over the payload only.

Parameters:
MAX_PAYLOAD, 1023, maximum payload bytes per packet; exceeding it aborts the packet.
CNT_W, 10, width of the payload byte counter; must satisfy 2^CNT_W > MAX_PAYLOAD.

Ports:
clk  in  1  system clock; all state changes on the rising edge
n_rst  in  1  reset, asynchronous, active-low
start  in  1  one-cycle pulse; begins a packet (ignored unless idle)
pid  in  4  PID code; sampled on an accepted start
zero_len  in  1  sampled on an accepted start; 1 = packet has no payload
in_data  in  8  payload byte from the endpoint buffer
in_valid  in  1  in_data is valid
in_last  in  1  qualifies in_data as the final payload byte
in_ready  out  1  payload byte is accepted when in_valid && in_ready
out_byte  out  8  byte to the encoder, LSB transmitted first
out_valid  out  1  out_byte is valid
out_last  out  1  marks the final byte of the packet (CRC high byte)
out_ready  in  1  encoder accepts out_byte when out_valid && out_ready
busy  out  1  high from the accepted start until the last byte is accepted
overflow  out  1  one-cycle pulse when a packet is aborted for exceeding MAX_PAYLOAD

Behaviour:
- Reset (async assert, n_rst low): state IDLE, crc=16'hFFFF, count=0, all outputs 0.
- start is accepted only in IDLE. In other states it is ignored.
- States and transitions:
  - IDLE:
    - On start: latch pid and zero_len, set crc=FFFF, count=0, then go to PID.
  - PID:
    - out_byte={~pid,pid}, out_valid=1.
    - On accept: go to CRC_LO if zero_len, else go to DATA.
  - DATA: combinational pass-through, no added latency.
    - out_byte=in_data, out_valid=in_valid, in_ready=out_ready.
    - On a transfer (in_valid && out_ready): update crc with in_data and increment count.
    - If in_last, go to CRC_LO.
    - in_valid low stalls the stream (out_valid=0). No timeout.
- CRC rules:
  - Polynomial x^16+x^15+x^2+1 (0x8005), initial value FFFF.
  - Data bits are processed LSB first, bit-serially: fb = d ^ crc[15]; crc = (crc<<1) ^ (fb ? 16'h8005 : 0).
  - All 8 bits are folded in a single cycle.
  - The CRC is frozen once the state leaves DATA.
- CRC_LO:
  - out_byte bit i = ~crc[15-i], for i = 0..7.
  - On accept: go to CRC_HI.
- CRC_HI:
  - out_byte bit i = ~crc[7-i], for i = 0..7. out_last=1.
  - On accept: busy drops and the state returns to IDLE on the same edge.
- Overflow:
  - Condition: a transfer with in_last=0 makes count reach MAX_PAYLOAD.
  - Response: pulse overflow and go to IDLE with no CRC emitted. The encoder side treats the missing out_last as an abort.
- Holding while stalled:
  - out_byte and out_last hold stable while out_valid && !out_ready (PID and CRC states).
  - in_ready=0 in every state except DATA.
- in_last in any state other than DATA has no effect.
- Reset mid-packet aborts immediately. No partial CRC is emitted after release.

Test Plan:
1. start, pid=4'h3 (DATA0), zero_len=1, out_ready=1 -> bytes C3, 00, 00 on consecutive cycles; out_last on the third byte; busy high for 3 cycles.
2. start, pid=4'hB (DATA1), payload 00 01 02 03 with in_last on 03 -> C3-style PID byte 4B, payload, 2 CRC bytes. The CRC bytes must match the bench bit-serial model, and feeding all 6 post-PID bytes through the receive CRC must yield residue 16'h800D.
3. Same as test 2 with out_ready toggling 1-0-1 and in_valid gaps -> identical byte sequence; no duplicates or drops; out_byte stable while stalled.
4. A 1023-byte payload with in_last on byte 1023 -> completes normally. A 1024-byte attempt without in_last -> overflow pulses on transfer 1023, state returns to IDLE, and no CRC bytes are sent.
5. start pulsed again during DATA -> ignored; the packet completes unchanged.
6. n_rst asserted in CRC_LO -> outputs 0 immediately. The next packet (zero_len) emits C3 00 00 with crc re-initialised.

Source files
------------

// File: rtl/usb_tx_data_packetizer_if.sv
// Bundle of the packetizer's control, payload-input and byte-output signals.
// Streams use valid/ready: a beat moves on a rising edge where valid && ready; once raised, valid and data hold until that edge.
interface usb_tx_data_packetizer_if;
  logic       start;
  logic [3:0] pid;
  logic       zero_len;
  logic [7:0] in_data;
  logic       in_valid;
  logic       in_last;
  logic       in_ready;
  logic [7:0] out_byte;
  logic       out_valid;
  logic       out_last;
  logic       out_ready;
  logic       busy;
  logic       overflow;
  logic [2:0] state;

  // master: the environment (endpoint buffer, encoder, controller); slave: the packetizer
  modport master (
    output start, pid, zero_len, in_data, in_valid, in_last, out_ready,
    input  in_ready, out_byte, out_valid, out_last, busy, overflow, state
  );

  modport slave (
    input  start, pid, zero_len, in_data, in_valid, in_last, out_ready,
    output in_ready, out_byte, out_valid, out_last, busy, overflow, state
  );
endinterface

// File: rtl/usb_tx_data_packetizer.sv
// USB DATAx/MDATA transmit framer: PID byte, payload pass-through, then the
// complemented, bit-reversed CRC16 of the payload. state is a debug view of the FSM.
module usb_tx_data_packetizer #(
  parameter int MAX_PAYLOAD = 1023,
  parameter int CNT_W       = 10
) (
  input logic                   clk,
  input logic                   n_rst,
  usb_tx_data_packetizer_if.slave bus
);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_PID    = 3'd1;
  localparam logic [2:0] S_DATA   = 3'd2;
  localparam logic [2:0] S_CRC_LO = 3'd3;
  localparam logic [2:0] S_CRC_HI = 3'd4;

  logic [2:0]       state_q, state_d;
  logic [3:0]       pid_q;
  logic             zl_q;
  logic [15:0]      crc_q;
  logic [CNT_W-1:0] count_q;
  logic             ovf_q;

  logic       in_xfer;
  logic       ovf_hit;
  logic [7:0] crc_lo_byte;
  logic [7:0] crc_hi_byte;

  // Bit-serial CRC16 (0x8005), data LSB first, all eight steps unrolled.
  function automatic logic [15:0] crc16_byte(input logic [15:0] c, input logic [7:0] d);
    logic [15:0] r;
    r = c;
    for (int i = 0; i < 8; i++) begin
      if (d[i] ^ r[15]) r = (r << 1) ^ 16'h8005;
      else              r = r << 1;
    end
    return r;
  endfunction

  assign in_xfer = (state_q == S_DATA) && bus.in_valid && bus.out_ready;
  assign ovf_hit = in_xfer && !bus.in_last &&
                   (count_q == CNT_W'(MAX_PAYLOAD - 1));

  // The CRC goes out complemented with its MSB on the wire first.
  always_comb begin
    crc_lo_byte = '0;
    crc_hi_byte = '0;
    for (int i = 0; i < 8; i++) begin
      crc_lo_byte[i] = ~crc_q[15-i];
      crc_hi_byte[i] = ~crc_q[7-i];
    end
  end

  always_comb begin
    bus.out_byte  = '0;
    bus.out_valid = 1'b0;
    bus.out_last  = 1'b0;
    bus.in_ready  = 1'b0;
    case (state_q)
      S_PID: begin
        bus.out_byte  = {~pid_q, pid_q};
        bus.out_valid = 1'b1;
      end
      S_DATA: begin
        bus.out_byte  = bus.in_data;
        bus.out_valid = bus.in_valid;
        bus.in_ready  = bus.out_ready;
      end
      S_CRC_LO: begin
        bus.out_byte  = crc_lo_byte;
        bus.out_valid = 1'b1;
      end
      S_CRC_HI: begin
        bus.out_byte  = crc_hi_byte;
        bus.out_valid = 1'b1;
        bus.out_last  = 1'b1;
      end
      default: ;
    endcase
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:   if (bus.start) state_d = S_PID;
      S_PID:    if (bus.out_ready) state_d = zl_q ? S_CRC_LO : S_DATA;
      S_DATA: begin
        if (in_xfer) begin
          if (bus.in_last)  state_d = S_CRC_LO;
          else if (ovf_hit) state_d = S_IDLE;
        end
      end
      S_CRC_LO: if (bus.out_ready) state_d = S_CRC_HI;
      S_CRC_HI: if (bus.out_ready) state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_q <= S_IDLE;
      pid_q   <= '0;
      zl_q    <= 1'b0;
      crc_q   <= 16'hFFFF;
      count_q <= '0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      ovf_q   <= ovf_hit;
      if (state_q == S_IDLE && bus.start) begin
        pid_q   <= bus.pid;
        zl_q    <= bus.zero_len;
        crc_q   <= 16'hFFFF;
        count_q <= '0;
      end
      // Only payload transfers touch the CRC, so it is frozen outside DATA.
      if (in_xfer) begin
        crc_q   <= crc16_byte(crc_q, bus.in_data);
        count_q <= count_q + 1'b1;
      end
    end
  end

  assign bus.busy     = (state_q != S_IDLE);
  assign bus.overflow = ovf_q;
  assign bus.state    = state_q;

endmodule
